// File: rtl/param_reg_file_sb.sv
// Parametrised register file with two combinational read ports, one write port,
// optional write-to-read bypass, optional hardwired zero register and a per-register busy scoreboard.
module param_reg_file_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [DATA_W-1:0]    IN,
  input  logic [ADDR_W-1:0]    INADDRESS,
  input  logic                 WRITE,
  input  logic [ADDR_W-1:0]    OUT1ADDRESS,
  input  logic [ADDR_W-1:0]    OUT2ADDRESS,
  output logic [DATA_W-1:0]    OUT1,
  output logic [DATA_W-1:0]    OUT2,
  input  logic                 SET_BUSY,
  input  logic [ADDR_W-1:0]    BUSYADDRESS,
  output logic                 OUT1_BUSY,
  output logic                 OUT2_BUSY,
  output logic                 STALL,
  output logic [2**ADDR_W-1:0] BUSY_VEC
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_ok;
  logic              sb_ok;

  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
  endfunction

  assign wr_ok = WRITE && !is_zero_addr(INADDRESS);
  assign sb_ok = SET_BUSY && !is_zero_addr(BUSYADDRESS);

  // data storage
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= {DATA_W{1'b0}};
    end else if (wr_ok) begin
      regs[INADDRESS] <= IN;
    end
  end

  // scoreboard: a same-cycle SET_BUSY overrides the clear from a write (new issue wins)
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      busy <= {DEPTH{1'b0}};
    end else begin
      if (wr_ok) busy[INADDRESS] <= 1'b0;
      if (sb_ok) busy[BUSYADDRESS] <= 1'b1;
    end
  end

  // read port 1; outputs are forced low while reset is held
  always_comb begin
    OUT1      = {DATA_W{1'b0}};
    OUT1_BUSY = 1'b0;
    if (!RESET_N || is_zero_addr(OUT1ADDRESS)) begin
      OUT1      = {DATA_W{1'b0}};
      OUT1_BUSY = 1'b0;
    end else if ((BYPASS != 0) && WRITE && (OUT1ADDRESS == INADDRESS)) begin
      OUT1      = IN;
      OUT1_BUSY = 1'b0;
    end else begin
      OUT1      = regs[OUT1ADDRESS];
      OUT1_BUSY = busy[OUT1ADDRESS];
    end
  end

  // read port 2
  always_comb begin
    OUT2      = {DATA_W{1'b0}};
    OUT2_BUSY = 1'b0;
    if (!RESET_N || is_zero_addr(OUT2ADDRESS)) begin
      OUT2      = {DATA_W{1'b0}};
      OUT2_BUSY = 1'b0;
    end else if ((BYPASS != 0) && WRITE && (OUT2ADDRESS == INADDRESS)) begin
      OUT2      = IN;
      OUT2_BUSY = 1'b0;
    end else begin
      OUT2      = regs[OUT2ADDRESS];
      OUT2_BUSY = busy[OUT2ADDRESS];
    end
  end

  // stall and busy vector
  always_comb begin
    STALL    = OUT1_BUSY | OUT2_BUSY;
    BUSY_VEC = {DEPTH{1'b0}};
    if (RESET_N) begin
      BUSY_VEC = busy;
      if (ZERO_REG != 0) BUSY_VEC[0] = 1'b0;
    end else begin
      BUSY_VEC = {DEPTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_param_reg_file_sb.sv
// Directed bench: three configurations (bypass, no bypass, zero register) share one stimulus stream.
module tb_param_reg_file_sb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_d;
  logic [2:0] in_a;
  logic       wr;
  logic [2:0] ra1, ra2;
  logic       sb;
  logic [2:0] ba;

  logic [7:0] o1_a, o2_a, o1_n, o2_n, o1_z, o2_z;
  logic       b1_a, b2_a, st_a, b1_n, b2_n, st_n, b1_z, b2_z, st_z;
  logic [7:0] bv_a, bv_n, bv_z;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  param_reg_file_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .IN(in_d), .INADDRESS(in_a), .WRITE(wr),
    .OUT1ADDRESS(ra1), .OUT2ADDRESS(ra2), .OUT1(o1_a), .OUT2(o2_a),
    .SET_BUSY(sb), .BUSYADDRESS(ba), .OUT1_BUSY(b1_a), .OUT2_BUSY(b2_a),
    .STALL(st_a), .BUSY_VEC(bv_a));

  param_reg_file_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) dut_n (
    .CLK(clk), .RESET_N(rst_n), .IN(in_d), .INADDRESS(in_a), .WRITE(wr),
    .OUT1ADDRESS(ra1), .OUT2ADDRESS(ra2), .OUT1(o1_n), .OUT2(o2_n),
    .SET_BUSY(sb), .BUSYADDRESS(ba), .OUT1_BUSY(b1_n), .OUT2_BUSY(b2_n),
    .STALL(st_n), .BUSY_VEC(bv_n));

  param_reg_file_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dut_z (
    .CLK(clk), .RESET_N(rst_n), .IN(in_d), .INADDRESS(in_a), .WRITE(wr),
    .OUT1ADDRESS(ra1), .OUT2ADDRESS(ra2), .OUT1(o1_z), .OUT2(o2_z),
    .SET_BUSY(sb), .BUSYADDRESS(ba), .OUT1_BUSY(b1_z), .OUT2_BUSY(b2_z),
    .STALL(st_z), .BUSY_VEC(bv_z));

  typedef struct {
    logic       wr;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       sb;
    logic [2:0] ba;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [7:0] e1;
    logic [7:0] e2;
    logic       eb1;
    logic       eb2;
    logic       est;
    logic [7:0] ebv;
    logic [7:0] e1nb;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                       input logic s, input logic [2:0] sa,
                       input logic [2:0] a1, input logic [2:0] a2);
    wr = w; in_a = wa; in_d = wd; sb = s; ba = sa; ra1 = a1; ra2 = a2;
  endtask

  initial begin
    // wr wa wd sb ba r1 r2 | e1 e2 eb1 eb2 est ebv | e1 without bypass
    vt[0]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd7, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[1]  = '{1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 3'd5, 3'd0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[2]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 3'd5, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3C};
    vt[3]  = '{1'b1, 3'd2, 8'h7E, 1'b0, 3'd0, 3'd2, 3'd5, 8'h7E, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[4]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd4, 3'd2, 8'h00, 8'h7E, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[5]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd4, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10, 8'h00};
    vt[6]  = '{1'b1, 3'd4, 8'h11, 1'b0, 3'd0, 3'd4, 3'd3, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00};
    vt[7]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd4, 8'h11, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11};
    vt[8]  = '{1'b1, 3'd4, 8'h11, 1'b1, 3'd4, 3'd4, 3'd5, 8'h11, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11};
    vt[9]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd2, 8'h11, 8'h7E, 1'b1, 1'b0, 1'b1, 8'h10, 8'h11};
    vt[10] = '{1'b1, 3'd6, 8'h99, 1'b1, 3'd1, 3'd6, 3'd1, 8'h99, 8'h00, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00};
    vt[11] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd1, 8'h99, 8'h00, 1'b0, 1'b1, 1'b1, 8'h12, 8'h99};
    vt[12] = '{1'b1, 3'd1, 8'hA0, 1'b0, 3'd0, 3'd1, 3'd4, 8'hA0, 8'h11, 1'b0, 1'b1, 1'b1, 8'h12, 8'h00};
    vt[13] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd1, 3'd4, 8'hA0, 8'h11, 1'b0, 1'b1, 1'b1, 8'h10, 8'hA0};
    vt[14] = '{1'b1, 3'd4, 8'hFF, 1'b0, 3'd0, 3'd7, 3'd2, 8'h00, 8'h7E, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00};
    vt[15] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd5, 8'hFF, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF};

    // reset held across an edge with a write and a busy request pending
    rst_n = 1'b0;
    drive(1'b1, 3'd3, 8'hA5, 1'b1, 3'd3, 3'd3, 3'd3);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out1_bypass", o1_a, 8'h00);
    chk("rst_out2", o2_a, 8'h00);
    chk("rst_busyvec", bv_a, 8'h00);
    chk("rst_stall", st_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd3);
    #1;
    chk("rst_r3_ignored", o1_a, 8'h00);
    chk("rst_r3_busy", b1_a, 1'b0);
    @(negedge clk);
    #1;
    chk("post_rst_busyvec", bv_a, 8'h00);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vt[i].wr, vt[i].wa, vt[i].wd, vt[i].sb, vt[i].ba, vt[i].r1, vt[i].r2);
      #1;
      chk($sformatf("v%0d_out1", i), o1_a, vt[i].e1);
      chk($sformatf("v%0d_out2", i), o2_a, vt[i].e2);
      chk($sformatf("v%0d_busy1", i), b1_a, vt[i].eb1);
      chk($sformatf("v%0d_busy2", i), b2_a, vt[i].eb2);
      chk($sformatf("v%0d_stall", i), st_a, vt[i].est);
      chk($sformatf("v%0d_busyvec", i), bv_a, vt[i].ebv);
      chk($sformatf("v%0d_out1_nobypass", i), o1_n, vt[i].e1nb);
    end

    // zero register: write and mark busy on r0
    @(negedge clk);
    drive(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 3'd0, 3'd0);
    #1;
    chk("z_bypass_r0", o1_z, 8'h00);
    chk("z_ref_bypass_r0", o1_a, 8'hFF);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
    #1;
    chk("z_r0_read", o1_z, 8'h00);
    chk("z_r0_busy", b1_z, 1'b0);
    chk("z_busyvec", bv_z, 8'h00);
    chk("z_ref_r0_read", o2_a, 8'hFF);
    chk("z_ref_busyvec", bv_a, 8'h01);
    chk("z_other_reg", o1_z, 8'h00);

    // mid-operation reset between edges
    @(negedge clk);
    drive(1'b1, 3'd1, 8'h55, 1'b1, 3'd6, 3'd1, 3'd6);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd1, 3'd6);
    #1;
    chk("mid_r1", o1_a, 8'h55);
    chk("mid_r6_busy", b2_a, 1'b1);
    chk("mid_busyvec", bv_a, 8'h41);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out1", o1_a, 8'h00);
    chk("mid_rst_busyvec", bv_a, 8'h00);
    chk("mid_rst_stall", st_a, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_r1_cleared", o1_a, 8'h00);
    chk("mid_rel_r6_busy", b2_a, 1'b0);
    chk("mid_rel_busyvec", bv_a, 8'h00);
    chk("mid_rel_nb_r1", o1_n, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
